// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue
// Instruction fetch stage. Owns the PC, issues in-order word fetches to
// instruction memory, buffers returned words in a small prefetch FIFO and
// drives the IF/ID register (IR + PC) into decode. A redirect flushes the
// FIFO and marks every outstanding fetch as stale so its word is discarded.
module riscv_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_ir,
    output logic [31:0] ifid_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_q;
    logic [31:0]   rsp_pc_q;
    logic [31:0]   fifo_ir [DEPTH];
    logic [31:0]   fifo_pc [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] drop_q;

    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          rsp_acc;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_aligned;

    // Request credit covers both buffered words and words still in flight,
    // so a returning word always has a FIFO slot waiting for it.
    always_comb begin
        credit_used      = {1'b0, count_q} + {1'b0, inflight_q};
        imem_req_valid   = !redirect_valid && (credit_used < (CW+1)'(DEPTH));
        imem_req_addr    = pc_q;
        req_fire         = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is illegal and simply ignored.
        rsp_acc          = imem_rsp_valid && (inflight_q != '0);
        rsp_drop         = rsp_acc && (drop_q != '0);
        push             = rsp_acc && !rsp_drop && !redirect_valid;
        pop              = !redirect_valid && !stall && (count_q != '0);
        redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
    end

    // Fetch PC and the PC of the next word that will actually be kept.
    // Responses return in order, so the kept-word PC only advances on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q     <= redirect_aligned;
            rsp_pc_q <= redirect_aligned;
        end else begin
            if (req_fire) pc_q     <= pc_q + 32'd4;
            if (push)     rsp_pc_q <= rsp_pc_q + 32'd4;
        end
    end

    // Outstanding-fetch and stale-word bookkeeping. On a redirect every word
    // still outstanding after this cycle is stale; drop can never exceed
    // inflight, so it is naturally bounded by DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            inflight_q <= inflight_q + CW'(req_fire) - CW'(rsp_acc);
            if (redirect_valid)
                drop_q <= inflight_q - CW'(rsp_acc);
            else if (rsp_drop)
                drop_q <= drop_q - CW'(1);
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_ir[wr_ptr_q] <= imem_rsp_data;
            fifo_pc[wr_ptr_q] <= rsp_pc_q;
        end
    end

    // IF/ID register: flush beats stall, stall holds, otherwise pop or bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid <= 1'b0;
            ifid_ir    <= NOP;
            ifid_pc    <= 32'h0;
        end else if (redirect_valid) begin
            ifid_valid <= 1'b0;
            ifid_ir    <= NOP;
        end else if (!stall) begin
            if (pop) begin
                ifid_valid <= 1'b1;
                ifid_ir    <= fifo_ir[rd_ptr_q];
                ifid_pc    <= fifo_pc[rd_ptr_q];
            end else begin
                ifid_valid <= 1'b0;
                ifid_ir    <= NOP;
            end
        end
    end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: a latency-programmable in-order memory model,
// a table of per-cycle expectations for streaming and stall, and directed
// sequences for redirect, redirect-with-stall and mid-stream reset.
module tb_riscv_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ifid_valid;
    logic [31:0] ifid_ir;
    logic [31:0] ifid_pc;

    riscv_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000),
        .NOP      (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_valid     (ifid_valid),
        .ifid_ir        (ifid_ir),
        .ifid_pc        (ifid_pc)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    int lat    = 1;
    int cyc    = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'h5A, a[23:0]};
    endfunction

    // In-order memory: record handshakes at the rising edge, present the
    // response so it is sampled exactly lat edges after the request.
    always begin
        @(posedge clk);
        cyc++;
        if (!rst_n)
            pend.delete();
        else if (imem_req_valid && imem_req_ready)
            pend.push_back('{imem_req_addr, cyc + lat});
        @(negedge clk);
        if (!rst_n) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic chk_ifid(input string name, input logic exp_valid, input logic [31:0] exp_pc);
        chk({name, "_valid"}, {31'b0, ifid_valid}, {31'b0, exp_valid});
        chk({name, "_pc"}, ifid_pc, exp_pc);
        chk({name, "_ir"}, ifid_ir, exp_valid ? mem_word(exp_pc) : NOP);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_pc(input string name, input logic [31:0] pc, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (ifid_valid && ifid_pc == pc) found = 1'b1;
        end
        chk({name, "_reached"}, {31'b0, found}, 32'd1);
    endtask

    task automatic wait_first_valid(input string name, input logic [31:0] exp_pc, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (ifid_valid) found = 1'b1;
        end
        chk({name, "_seen"}, {31'b0, found}, 32'd1);
        if (found) chk_ifid(name, 1'b1, exp_pc);
    endtask

    typedef struct {
        logic        stall;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_req_valid;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // Zero-wait memory streaming, then three stall cycles holding pc 8.
        vecs[0]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h04};
        vecs[1]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
        vecs[2]  = '{1'b0, 1'b1, 32'h00, 1'b1, 32'h0C};
        vecs[3]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h10};
        vecs[4]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h14};
        vecs[5]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h18};
        vecs[6]  = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h1C};
        vecs[7]  = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h1C};
        vecs[8]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h1C};
        vecs[9]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h20};
        vecs[10] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h24};
        vecs[11] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h28};
        vecs[12] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h2C};

        // Reset state and streaming/stall table
        lat = 1;
        do_reset();
        chk_ifid("rst", 1'b0, 32'h0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        for (int i = 0; i < 13; i++) begin
            stall = vecs[i].stall;
            tick();
            chk_ifid($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
            chk($sformatf("vec%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].exp_req_valid});
            chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].exp_addr);
        end
        stall = 1'b0;

        // Memory not ready: request held at reset PC, nothing reaches decode
        do_reset();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("nrdy%0d_req_valid", i), {31'b0, imem_req_valid}, 32'd1);
            chk($sformatf("nrdy%0d_req_addr", i), imem_req_addr, 32'h0);
            chk($sformatf("nrdy%0d_ifid_valid", i), {31'b0, ifid_valid}, 32'd0);
            chk($sformatf("nrdy%0d_ifid_ir", i), ifid_ir, NOP);
        end
        imem_req_ready = 1'b1;

        // Latency-3 memory, two fetches in flight, redirect to 0x100
        do_reset();
        lat = 3;
        tick();
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        chk_ifid("redir", 1'b0, 32'h0);
        chk("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
        redirect_valid = 1'b0;
        #1;
        chk("redir_new_addr", imem_req_addr, 32'h0000_0100);
        imem_req_ready = 1'b1;
        wait_first_valid("redir_first", 32'h0000_0100, 20);
        tick();
        chk_ifid("redir_second", 1'b1, 32'h0000_0104);

        // Redirect and stall together: flush wins
        do_reset();
        lat = 1;
        wait_pc("rs_wait", 32'h20, 30);
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        chk("rs_flush_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rs_flush_ir", ifid_ir, NOP);
        stall          = 1'b0;
        redirect_valid = 1'b0;
        wait_first_valid("rs_resume", 32'h0000_0200, 30);

        // Asynchronous reset with three words buffered
        do_reset();
        lat = 1;
        wait_pc("ar_wait", 32'h08, 30);
        stall = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_ifid("ar_async", 1'b0, 32'h0);
        chk("ar_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;
        chk("ar_rel_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("ar_rel_req_addr", imem_req_addr, 32'h0);
        wait_first_valid("ar_first", 32'h0, 20);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
